decodor_pwm: RTL and testbench
==============================

# decodor_pwm

PWM duty-cycle decoder: the receive end of the motor PWM path. Samples one PWM line (a generator output or an external PWM source) and reports its high time as a 3-digit BCD duty factor on the same 000–999 scale the PWM generator consumes, plus the measured period and status flags. Sits beside the generator for closed-loop self-test and for reading PWM-coded sensors.

## Interface
- `PERIOD`, 1000: expected period in clock cycles; compared against every measured period.
- `TIMEOUT`, 1100: cycles without any edge before the line is declared static.
- `clock`  in  1  50 MHz board clock.
- `reset`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  asynchronous PWM line.
- `factor_PWM_out`  out  12  BCD duty factor {sute, zeci, unitati}; equals the generator factor that produces the observed waveform.
- `perioada_out`  out  11  measured period in cycles, binary, saturating at 2047.
- `valid`  out  1  one-cycle pulse when new outputs are published.
- `static_line`  out  1  1 = last result came from timeout (no edges).
- `err_perioada`  out  1  1 = last published period ≠ PERIOD.

## Operation
- `pwm_in` passes a 2-flop synchronizer, then a third flop for edge detection: rise = s & ~s_d, fall = ~s & s_d.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise (partial pulses after reset are discarded). On rise -> HIGH, BCD counter := 000, period counter := 1.
  - HIGH: each cycle with s=1 and no fall, BCD counter +1 (digit carry 9->0 with increment of next digit, saturate at 999, no wrap). Period counter +1 every cycle. On fall -> LOW, latch BCD counter into holding register.
  - LOW: period counter +1. On rise -> publish: `factor_PWM_out` := holding register, `perioada_out` := period counter, `err_perioada` := (period ≠ PERIOD), `static_line` := 0, `valid` := 1; restart as in IDLE->HIGH (same cycle, no lost cycle).
- High lasting N cycles yields BCD value N−1 (rise cycle counts as 000).
- Timeout: idle counter reset on any edge, increments otherwise, saturates. When it reaches TIMEOUT (any state): publish `factor_PWM_out` := s ? 12'h999 : 12'h000, `perioada_out` := 0, `static_line` := 1, `err_perioada` := 0, `valid` := 1; FSM -> IDLE; counter holds so the timeout publishes once per static episode.
- Period counter saturates at 2047; saturated period always sets `err_perioada`.
- Simultaneous rise and timeout in the same cycle: rise wins, timeout suppressed.

## Timing
- Reset: all outputs 0 (`factor_PWM_out` 12'h000, `perioada_out` 0, flags 0), FSM IDLE, synchronizer flops 0. Reset mid-measurement discards the partial measurement; outputs return to 0 the cycle after reset is sampled.
- Pin-to-edge-detect latency: 3 clocks.
- `valid` asserts the cycle after the detected rise that closes a period; outputs registered and stable until the next `valid`.
- First `valid` after reset or after a static episode: after one full period following the first rise (≥ 2 rises).

## Structure
- Shared package/header: BCD digit width (4), BCD max 12'h999, FSM state encodings, default PERIOD/TIMEOUT.
- One natural sub-module: `numarator_bcd_sat` — 3-digit BCD counter with clear, enable, saturation at 999; reusable by the generator.

## Test plan
- Generator-style waveform, high 501 cycles, period 1000 -> `factor_PWM_out`=12'h500, `perioada_out`=1000, `err_perioada`=0, `valid` once per period.
- High 1 cycle, period 1000 -> 12'h000, `static_line`=0; repeat with high 1000 (never low) -> after 1100 cycles 12'h999, `static_line`=1, single `valid`.
- Line held low from reset -> one `valid` at TIMEOUT with 12'h000, `static_line`=1; then normal pulses resume -> normal results after two rises.
- Period 800, high 200 -> 12'h199, `perioada_out`=800, `err_perioada`=1.
- Reset asserted mid-HIGH -> outputs 0 next cycle, no `valid` until a full subsequent period completes.
- Single-cycle glitches and pulse lengths 9/10/99/100/999/1200 -> correct BCD carries and saturation at 12'h999.

Source files
------------

// File: rtl/decodor_pwm_pkg.sv
// decodor_pwm_pkg: shared BCD widths, FSM encodings and defaults for the PWM decoder.
package decodor_pwm_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_W = 3 * DIGIT_W;
  localparam int PER_W = 11;
  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;
  localparam int PERIOD_DEF = 1000;
  localparam int TIMEOUT_DEF = 1100;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} stare_t;
  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (v != BCD_MAX) begin
      r[3:0] = (v[3:0] == 4'd9) ? 4'd0 : v[3:0] + 4'd1;
      r[7:4] = (v[3:0] != 4'd9) ? v[7:4] : (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      r[11:8] = (v[7:0] != 8'h99) ? v[11:8] : v[11:8] + 4'd1;
    end
    return r;
  endfunction
endpackage

// File: rtl/decodor_pwm_if.sv
// decodor_pwm_if: PWM line in, measured duty/period/status out.
interface decodor_pwm_if;
  import decodor_pwm_pkg::*;
  logic pwm_in;
  logic [BCD_W-1:0] factor_PWM_out;
  logic [PER_W-1:0] perioada_out;
  logic valid;
  logic static_line;
  logic err_perioada;
  modport master (output pwm_in, input factor_PWM_out, perioada_out, valid, static_line, err_perioada);
  modport slave (input pwm_in, output factor_PWM_out, perioada_out, valid, static_line, err_perioada);
endinterface

// File: rtl/decodor_pwm_numarator.sv
// numarator_bcd_sat: 3-digit BCD counter with clear, enable and saturation at 999.
module numarator_bcd_sat
  import decodor_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [BCD_W-1:0] q_o
);
  logic [BCD_W-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : en_i ? bcd_inc_sat(q_q) : q_q;
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/decodor_pwm.sv
// decodor_pwm: measures PWM high time as a BCD duty factor plus period and status flags.
module decodor_pwm
  import decodor_pwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clock,
  input logic          reset,
  decodor_pwm_if.slave bus
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  stare_t state_q, state_d;
  logic [2:0] sync_q;
  logic s, rise, fall, tmo, publish, latch, bcd_en, per_sat;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [PER_W-1:0] per_q, per_d, per_out_q, per_out_d;
  logic [BCD_W-1:0] bcd, hold_q, hold_d, fac_q, fac_d;
  logic valid_q, valid_d, stat_q, stat_d, err_q, err_d;
  assign s = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
  // any edge resets the idle count, so a rise always beats a coincident timeout
  assign tmo = ~(rise | fall) & (idle_q == IDLE_W'(TIMEOUT - 1));
  assign per_sat = &per_q;
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;
  always_comb state_d = rise ? HIGH : tmo ? IDLE : (state_q == HIGH && fall) ? LOW : state_q;
  always_comb begin
    bcd_en = state_q == HIGH && s;
    latch = state_q == HIGH && fall;
    publish = state_q == LOW && rise;
  end
  numarator_bcd_sat u_bcd (
    .clk  (clock),
    .rst  (reset),
    .clr_i(rise),
    .en_i (bcd_en),
    .q_o  (bcd)
  );
  always_comb begin
    idle_d = (rise | fall) ? '0 : (idle_q == IDLE_W'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
    per_d = rise ? PER_W'(1) : (state_q != IDLE && !per_sat) ? per_q + 1'b1 : per_q;
    hold_d = latch ? bcd : hold_q;
    fac_d = publish ? hold_q : tmo ? (s ? BCD_MAX : '0) : fac_q;
    per_out_d = publish ? per_q : tmo ? '0 : per_out_q;
    err_d = publish ? (per_sat || per_q != PER_W'(PERIOD)) : tmo ? 1'b0 : err_q;
    stat_d = publish ? 1'b0 : tmo ? 1'b1 : stat_q;
    valid_d = publish | tmo;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      idle_q <= '0;
      per_q <= '0;
      hold_q <= '0;
      fac_q <= '0;
      per_out_q <= '0;
      err_q <= 1'b0;
      stat_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.pwm_in};
      idle_q <= idle_d;
      per_q <= per_d;
      hold_q <= hold_d;
      fac_q <= fac_d;
      per_out_q <= per_out_d;
      err_q <= err_d;
      stat_q <= stat_d;
      valid_q <= valid_d;
    end
  end
  assign bus.factor_PWM_out = fac_q;
  assign bus.perioada_out = per_out_q;
  assign bus.valid = valid_q;
  assign bus.static_line = stat_q;
  assign bus.err_perioada = err_q;
endmodule

// File: tb/tb_decodor_pwm.sv
// tb_decodor_pwm: directed waveforms with hand-computed duty, period and flag results.
module tb_decodor_pwm;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  int vcnt = 0;
  int base;
  decodor_pwm_if bus ();
  decodor_pwm #(.PERIOD(1000), .TIMEOUT(1100)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (!reset && bus.valid) vcnt++;
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic apply_reset;
    bus.pwm_in = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
  endtask
  task automatic pulses(input int h, input int p, input int k);
    repeat (k) begin
      bus.pwm_in = 1'b1;
      cyc(h);
      bus.pwm_in = 1'b0;
      cyc(p - h);
    end
  endtask
  task automatic test_reset;
    bus.pwm_in = 1'b0;
    reset = 1'b1;
    cyc(3);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada});
    end
    reset = 1'b0;
    cyc(2);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada} !== 26'd0) begin
      errors++;
      $display("FAIL post_reset_idle got %h want 0", {bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada});
    end
  endtask
  task automatic test_duty_500;
    apply_reset();
    base = vcnt;
    pulses(501, 1000, 3);
    bus.pwm_in = 1'b1;
    cyc(6);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada} !== {12'h500, 11'd1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL duty500 got %h/%0d/%b/%b want 500/1000/0/0", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada);
    end
    vectors++;
    if (vcnt - base !== 3) begin
      errors++;
      $display("FAIL duty500_valids got %0d want 3", vcnt - base);
    end
  endtask
  task automatic test_short_and_stuck_high;
    apply_reset();
    base = vcnt;
    pulses(1, 1000, 2);
    bus.pwm_in = 1'b1;
    cyc(6);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada} !== {12'h000, 11'd1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL high1 got %h/%0d/%b/%b want 000/1000/0/0", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada);
    end
    vectors++;
    if (vcnt - base !== 2) begin
      errors++;
      $display("FAIL high1_valids got %0d want 2", vcnt - base);
    end
    base = vcnt;
    cyc(1090);
    vectors++;
    if (vcnt - base !== 0) begin
      errors++;
      $display("FAIL stuck_high_early got %0d valids want 0", vcnt - base);
    end
    cyc(20);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada} !== {12'h999, 11'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stuck_high got %h/%0d/%b/%b want 999/0/1/0", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada);
    end
    cyc(1500);
    vectors++;
    if (vcnt - base !== 1) begin
      errors++;
      $display("FAIL stuck_high_valids got %0d want 1", vcnt - base);
    end
  endtask
  task automatic test_static_low;
    apply_reset();
    base = vcnt;
    cyc(1090);
    vectors++;
    if (vcnt - base !== 0) begin
      errors++;
      $display("FAIL static_low_early got %0d valids want 0", vcnt - base);
    end
    cyc(20);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base} !== {12'h000, 11'd0, 1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL static_low got %h/%0d/%b/%b valids %0d want 000/0/1/0 valids 1", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base);
    end
    base = vcnt;
    pulses(501, 1000, 1);
    vectors++;
    if (vcnt - base !== 0) begin
      errors++;
      $display("FAIL resume_one_rise got %0d valids want 0", vcnt - base);
    end
    bus.pwm_in = 1'b1;
    cyc(6);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base} !== {12'h500, 11'd1000, 1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL resume got %h/%0d/%b/%b valids %0d want 500/1000/0/0 valids 1", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base);
    end
  endtask
  task automatic test_period_800;
    apply_reset();
    base = vcnt;
    pulses(200, 800, 2);
    bus.pwm_in = 1'b1;
    cyc(6);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base} !== {12'h199, 11'd800, 1'b0, 1'b1, 32'd2}) begin
      errors++;
      $display("FAIL period800 got %h/%0d/%b/%b valids %0d want 199/800/0/1 valids 2", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, vcnt - base);
    end
  endtask
  task automatic test_reset_mid_high;
    apply_reset();
    pulses(501, 1000, 1);
    bus.pwm_in = 1'b1;
    cyc(100);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada} !== {12'h500, 11'd1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset got %h/%0d/%b/%b want 500/1000/0/0", bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada);
    end
    reset = 1'b1;
    cyc(1);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada} !== 26'd0) begin
      errors++;
      $display("FAIL mid_high_reset got %h want 0", {bus.factor_PWM_out, bus.perioada_out, bus.valid, bus.static_line, bus.err_perioada});
    end
    bus.pwm_in = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    base = vcnt;
    pulses(501, 1000, 1);
    vectors++;
    if (vcnt - base !== 0) begin
      errors++;
      $display("FAIL after_reset_one_rise got %0d valids want 0", vcnt - base);
    end
    bus.pwm_in = 1'b1;
    cyc(6);
    vectors++;
    if ({bus.factor_PWM_out, bus.perioada_out, vcnt - base} !== {12'h500, 11'd1000, 32'd1}) begin
      errors++;
      $display("FAIL after_reset got %h/%0d valids %0d want 500/1000 valids 1", bus.factor_PWM_out, bus.perioada_out, vcnt - base);
    end
  endtask
  task automatic test_bcd_carries;
    int h[9] = '{9, 10, 99, 100, 999, 1050, 300, 1, 10};
    int p[9] = '{1000, 1000, 1000, 1000, 1000, 1100, 301, 50, 10};
    logic [11:0] f[8] = '{12'h008, 12'h009, 12'h098, 12'h099, 12'h998, 12'h999, 12'h299, 12'h000};
    apply_reset();
    base = vcnt;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < p[i]; c++) begin
        bus.pwm_in = (c < h[i]);
        @(negedge clock);
        if (i > 0 && c == 5) begin
          vectors++;
          if ({bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada} !== {f[i-1], 11'(p[i-1]), 1'b0, p[i-1] != 1000}) begin
            errors++;
            $display("FAIL carry_h%0d got %h/%0d/%b/%b want %h/%0d/0/%b", h[i-1], bus.factor_PWM_out, bus.perioada_out, bus.static_line, bus.err_perioada, f[i-1], p[i-1], p[i-1] != 1000);
          end
        end
      end
    end
    vectors++;
    if (vcnt - base !== 8) begin
      errors++;
      $display("FAIL carry_valids got %0d want 8", vcnt - base);
    end
  endtask
  initial begin
    bus.pwm_in = 1'b0;
    test_reset();
    test_duty_500();
    test_short_and_stuck_high();
    test_static_low();
    test_period_800();
    test_reset_mid_high();
    test_bcd_carries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
